// File: rtl/outagu_nd.sv
// outagu_nd: nested-loop output address generator for quantizer writes.
// Ports: clk, clr (sync reset), load/baseaddr/strides/lengths (config),
//   step (advance), addrout/busy/done/wrap (status).
//   OUTAGU_ND_BOUNDS_EN adds hilimit (in) and a sticky oob flag (out).
module outagu_nd #(
  parameter int BDBANKA = 15,
  parameter int NLOOPS  = 3,
  parameter int BLENGTH = 10
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       load,
  input  logic [BDBANKA-1:0]         baseaddr,
  input  logic [NLOOPS*BDBANKA-1:0]  strides,
  input  logic [NLOOPS*BLENGTH-1:0]  lengths,
  input  logic                       step,
`ifdef OUTAGU_ND_BOUNDS_EN
  input  logic [BDBANKA-1:0]         hilimit,
  output logic                       oob,
`endif
  output logic [BDBANKA-1:0]         addrout,
  output logic                       busy,
  output logic                       done,
  output logic [NLOOPS-1:0]          wrap
);

  logic [BDBANKA-1:0]                   addr;
  logic [BDBANKA-1:0]                   base_q;
  logic [NLOOPS-1:0][BDBANKA-1:0]       stride_q;
  logic [NLOOPS-1:0][BLENGTH-1:0]       len_q;
  logic [NLOOPS-1:0][BLENGTH-1:0]       cnt;
  logic                                 busy_q;
  logic                                 done_q;
  logic [NLOOPS-1:0]                    wrap_q;

  logic [BDBANKA-1:0]                   nxt_addr;
  logic [NLOOPS-1:0][BLENGTH-1:0]       nxt_cnt;
  logic [NLOOPS-1:0]                    nxt_wrap;
  logic                                 hit;
  logic                                 adv;

`ifdef OUTAGU_ND_BOUNDS_EN
  logic [BDBANKA-1:0] hilim_q;
  logic               oob_q;
  logic [BDBANKA:0]   ext_sum;
  logic               oob_hit;
`endif

  // Last count index of a level; a length of 0 behaves as 1.
  function automatic logic [BLENGTH-1:0] last_of(
    input logic [BLENGTH-1:0] l
  );
    if (l == '0) return '0;
    return l - BLENGTH'(1);
  endfunction

  assign adv = step & busy_q & ~load & ~clr;

  // Ripple from the innermost level: every level sitting at its last
  // count wraps to 0 until the first one that can still increment.
  // If none can, this is the final step and the address returns to base.
  always_comb begin
    hit      = 1'b0;
    nxt_addr = base_q;
    nxt_cnt  = '0;
    nxt_wrap = '0;
`ifdef OUTAGU_ND_BOUNDS_EN
    ext_sum  = '0;
    oob_hit  = 1'b0;
`endif
    for (int i = 0; i < NLOOPS; i++) begin
      if (hit) begin
        nxt_cnt[i] = cnt[i];
      end else if (cnt[i] == last_of(len_q[i])) begin
        nxt_cnt[i]  = '0;
        nxt_wrap[i] = 1'b1;
      end else begin
        nxt_cnt[i] = cnt[i] + BLENGTH'(1);
        hit        = 1'b1;
`ifdef OUTAGU_ND_BOUNDS_EN
        // One extra bit catches carry (positive) or borrow (negative).
        ext_sum  = {1'b0, addr}
                 + {stride_q[i][BDBANKA-1], stride_q[i]};
        nxt_addr = ext_sum[BDBANKA-1:0];
        oob_hit  = ext_sum[BDBANKA]
                 | (ext_sum[BDBANKA-1:0] > hilim_q);
`else
        nxt_addr = addr + stride_q[i];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      addr     <= '0;
      base_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= '0;
    end else if (load) begin
      addr   <= baseaddr;
      base_q <= baseaddr;
      for (int i = 0; i < NLOOPS; i++) begin
        stride_q[i] <= strides[i*BDBANKA +: BDBANKA];
        len_q[i]    <= lengths[i*BLENGTH +: BLENGTH];
      end
      cnt    <= '0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
      wrap_q <= '0;
    end else if (adv) begin
      addr   <= nxt_addr;
      cnt    <= nxt_cnt;
      busy_q <= hit;
      done_q <= ~hit;
      wrap_q <= nxt_wrap;
    end else begin
      done_q <= 1'b0;
      wrap_q <= '0;
    end
  end

`ifdef OUTAGU_ND_BOUNDS_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      hilim_q <= '0;
      oob_q   <= 1'b0;
    end else if (load) begin
      hilim_q <= hilimit;
      oob_q   <= 1'b0;
    end else if (adv && hit && oob_hit) begin
      oob_q <= 1'b1;
    end
  end

  assign oob = oob_q;
`endif

  assign addrout = addr;
  assign busy    = busy_q;
  assign done    = done_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_outagu_nd.sv
// tb_outagu_nd: directed checks of outagu_nd sequencing.
// Covers linear, 2-D tile, negative stride, priority, idle, zero length.
module tb_outagu_nd;

  localparam int BDBANKA = 15;
  localparam int NLOOPS  = 3;
  localparam int BLENGTH = 10;

  logic                      clk = 1'b0;
  logic                      clr;
  logic                      load;
  logic [BDBANKA-1:0]        baseaddr;
  logic [NLOOPS*BDBANKA-1:0] strides;
  logic [NLOOPS*BLENGTH-1:0] lengths;
  logic                      step;
  logic [BDBANKA-1:0]        addrout;
  logic                      busy;
  logic                      done;
  logic [NLOOPS-1:0]         wrap;
`ifdef OUTAGU_ND_BOUNDS_EN
  logic [BDBANKA-1:0]        hilimit;
  logic                      oob;
`endif

  int n_chk = 0;
  int n_err = 0;

  outagu_nd #(
    .BDBANKA(BDBANKA),
    .NLOOPS (NLOOPS),
    .BLENGTH(BLENGTH)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .load    (load),
    .baseaddr(baseaddr),
    .strides (strides),
    .lengths (lengths),
    .step    (step),
`ifdef OUTAGU_ND_BOUNDS_EN
    .hilimit (hilimit),
    .oob     (oob),
`endif
    .addrout (addrout),
    .busy    (busy),
    .done    (done),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_load(
    input logic [BDBANKA-1:0]        b,
    input logic [NLOOPS*BDBANKA-1:0] s,
    input logic [NLOOPS*BLENGTH-1:0] l,
    input logic                      with_step
  );
    @(negedge clk);
    baseaddr = b;
    strides  = s;
    lengths  = l;
    load     = 1'b1;
    step     = with_step;
    @(negedge clk);
    load = 1'b0;
    step = 1'b0;
  endtask

  task automatic do_step();
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic chk_st(
    input string tag,
    input int    a,
    input int    b,
    input int    d,
    input int    w
  );
    chk({tag, ".addr"}, 32'(addrout), a);
    chk({tag, ".busy"}, 32'(busy), b);
    chk({tag, ".done"}, 32'(done), d);
    chk({tag, ".wrap"}, 32'(wrap), w);
  endtask

  int tile [12] = '{1, 2, 3, 16, 17, 18, 19, 32, 33, 34, 35, 0};
  int neg  [4]  = '{1, 0, 32767, 2};

  initial begin
    clr      = 1'b1;
    load     = 1'b0;
    step     = 1'b0;
    baseaddr = '0;
    strides  = '0;
    lengths  = '0;
`ifdef OUTAGU_ND_BOUNDS_EN
    hilimit  = '0;
`endif
    repeat (3) @(negedge clk);
    chk_st("reset", 0, 0, 0, 0);
    clr = 1'b0;

    // Linear: 8 steps from 100
    do_load(15'd100, {15'd0, 15'd0, 15'd1},
            {10'd1, 10'd1, 10'd8}, 1'b0);
    chk_st("lin.load", 100, 1, 0, 0);
    for (int s = 1; s <= 8; s++) begin
      do_step();
      chk_st($sformatf("lin.s%0d", s),
             (s < 8) ? 100 + s : 100,
             (s < 8) ? 1 : 0,
             (s == 8) ? 1 : 0,
             (s == 8) ? 7 : 0);
    end
    @(negedge clk);
    chk_st("lin.after", 100, 0, 0, 0);

    // Idle step is ignored
    do_step();
    chk_st("idle", 100, 0, 0, 0);

    // 2-D tile 4x3, jump 13 on row change
    do_load(15'd0, {15'd0, 15'd13, 15'd1},
            {10'd1, 10'd3, 10'd4}, 1'b0);
    chk_st("tile.load", 0, 1, 0, 0);
    for (int s = 1; s <= 12; s++) begin
      do_step();
      chk_st($sformatf("tile.s%0d", s), tile[s-1],
             (s < 12) ? 1 : 0,
             (s == 12) ? 1 : 0,
             (s == 12) ? 7 : ((s == 4 || s == 8) ? 1 : 0));
    end

    // Negative stride through address zero
    do_load(15'd2, {15'd0, 15'd0, 15'h7FFF},
            {10'd1, 10'd1, 10'd4}, 1'b0);
    for (int s = 1; s <= 4; s++) begin
      do_step();
      chk_st($sformatf("neg.s%0d", s), neg[s-1],
             (s < 4) ? 1 : 0,
             (s == 4) ? 1 : 0,
             (s == 4) ? 7 : 0);
    end

    // Load with simultaneous step restarts, step dropped
    do_load(15'd50, {15'd0, 15'd0, 15'd1},
            {10'd1, 10'd1, 10'd8}, 1'b0);
    do_step();
    do_step();
    chk_st("pri.mid", 52, 1, 0, 0);
    do_load(15'd200, {15'd0, 15'd0, 15'd1},
            {10'd1, 10'd1, 10'd8}, 1'b1);
    chk_st("pri.ld", 200, 1, 0, 0);
    do_step();
    chk_st("pri.s1", 201, 1, 0, 0);

    // clr wins over load, aborts without done
    @(negedge clk);
    clr  = 1'b1;
    load = 1'b1;
    @(negedge clk);
    clr  = 1'b0;
    load = 1'b0;
    chk_st("clr.ld", 0, 0, 0, 0);
    do_step();
    chk_st("clr.step", 0, 0, 0, 0);

    // All lengths zero: first step finishes
    do_load(15'd77, {15'd5, 15'd5, 15'd5},
            {10'd0, 10'd0, 10'd0}, 1'b0);
    chk_st("zl.load", 77, 1, 0, 0);
    do_step();
    chk_st("zl.s1", 77, 0, 1, 7);

`ifdef OUTAGU_ND_BOUNDS_EN
    hilimit = 15'd105;
    do_load(15'd100, {15'd0, 15'd0, 15'd1},
            {10'd1, 10'd1, 10'd8}, 1'b0);
    chk("oob.load", 32'(oob), 0);
    for (int s = 1; s <= 8; s++) begin
      do_step();
      chk($sformatf("oob.s%0d", s), 32'(oob),
          (s >= 6) ? 1 : 0);
    end
    do_load(15'd100, {15'd0, 15'd0, 15'd1},
            {10'd1, 10'd1, 10'd8}, 1'b0);
    chk("oob.reld", 32'(oob), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
